keccak_feeder: RTL and testbench

Upstream stage of the keccak core. It accepts a message as a stream of 32-bit words with a valid/ready handshake and packs them into 544-bit rate chunks. It presents each chunk to the keccak input with the in_ready/is_last/byte_num protocol, throttled by buffer_full. One message is sent per reset; after the final chunk the block holds in DONE until reset.

---
 rtl/keccak_pkg.sv | 16 +
 rtl/keccak_feeder_if.sv | 27 ++
 rtl/keccak_feeder.sv | 138 +++++++++++++
 tb/tb_keccak_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the keccak message feeder.
package keccak_pkg;

   localparam int WORD_W          = 32;
   localparam int BLOCK_W         = 544;
   localparam int BLOCK_BYTES     = 68;
   localparam int WORDS_PER_BLOCK = 17;

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      SEND      = 2'd1,
      SEND_LAST = 2'd2,
      DONE      = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/keccak_feeder_if.sv
// Word-stream input and chunk output of the keccak feeder; slave is the feeder's view.
interface keccak_feeder_if;
   import keccak_pkg::*;

   logic [WORD_W-1:0]  s_data;
   logic               s_valid;
   logic               s_last;
   logic [2:0]         s_bytes;
   logic               s_ready;

   logic [BLOCK_W-1:0] k_in;
   logic               k_in_ready;
   logic               k_is_last;
   logic [7:0]         k_byte_num;
   logic               k_buffer_full;

   modport slave (
      input  s_data, s_valid, s_last, s_bytes, k_buffer_full,
      output s_ready, k_in, k_in_ready, k_is_last, k_byte_num
   );

   modport master (
      output s_data, s_valid, s_last, s_bytes, k_buffer_full,
      input  s_ready, k_in, k_in_ready, k_is_last, k_byte_num
   );

endinterface

// File: rtl/keccak_feeder.sv
// Packs a 32-bit word stream into 544-bit rate chunks and hands them to keccak,
// one message per reset.
module keccak_feeder
   import keccak_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   keccak_feeder_if.slave bus,
   output logic           busy,
   output logic           done
);

   feeder_state_t      state;
   logic [4:0]         count;
   logic               pend_empty;
   logic [BLOCK_W-1:0] chunk;
   logic [7:0]         last_bytes;
   logic               s_ready_r;
   logic               pulse;
   logic               is_last_r;
   logic [7:0]         byte_num_r;

   logic               accept;
   logic               fire;
   logic [2:0]         nb_c;
   logic [7:0]         nbytes_c;
   logic [WORD_W-1:0]  word_c;

   function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
      return (n > 3'd4) ? 3'd4 : n;
   endfunction

   function automatic logic [WORD_W-1:0] mask_word(input logic [WORD_W-1:0] w,
                                                   input logic [2:0]        n);
      logic [WORD_W-1:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         if (3'(i) < clamp_bytes(n))
            m[WORD_W-1-8*i -: 8] = 8'hFF;
      end
      return w & m;
   endfunction

   assign accept   = bus.s_valid && s_ready_r;
   assign nb_c     = clamp_bytes(bus.s_bytes);
   assign nbytes_c = {1'b0, count, 2'b00} + {5'b0, nb_c};
   assign word_c   = bus.s_last ? mask_word(bus.s_data, bus.s_bytes) : bus.s_data;
   // A pulse cycle is never followed directly by another pulse.
   assign fire     = (state == SEND || state == SEND_LAST) && !bus.k_buffer_full && !pulse;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FILL;
         count      <= '0;
         pend_empty <= 1'b0;
         chunk      <= '0;
         last_bytes <= '0;
         s_ready_r  <= 1'b1;
         pulse      <= 1'b0;
         is_last_r  <= 1'b0;
         byte_num_r <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         pulse      <= 1'b0;
         is_last_r  <= 1'b0;
         byte_num_r <= '0;
         // The delivered chunk stays on k_in through its pulse, then clears.
         if (pulse)
            chunk <= '0;

         unique case (state)
            FILL: begin
               if (accept) begin
                  busy <= 1'b1;
                  if (count == 5'd0)
                     chunk <= {word_c, {(BLOCK_W-WORD_W){1'b0}}};
                  else
                     chunk[BLOCK_W-1-WORD_W*int'(count) -: WORD_W] <= word_c;

                  if (bus.s_last) begin
                     s_ready_r <= 1'b0;
                     if (nbytes_c == 8'(BLOCK_BYTES)) begin
                        state      <= SEND;
                        pend_empty <= 1'b1;
                     end else begin
                        state      <= SEND_LAST;
                        last_bytes <= nbytes_c;
                     end
                  end else if (count == 5'(WORDS_PER_BLOCK-1)) begin
                     state     <= SEND;
                     s_ready_r <= 1'b0;
                  end else begin
                     count <= count + 5'd1;
                  end
               end
            end

            SEND: begin
               if (fire) begin
                  pulse <= 1'b1;
                  count <= '0;
                  if (pend_empty) begin
                     // Exactly-full final chunk still owes keccak an empty last chunk.
                     state      <= SEND_LAST;
                     pend_empty <= 1'b0;
                     last_bytes <= '0;
                  end else begin
                     state     <= FILL;
                     s_ready_r <= 1'b1;
                  end
               end
            end

            SEND_LAST: begin
               if (fire) begin
                  pulse      <= 1'b1;
                  is_last_r  <= 1'b1;
                  byte_num_r <= last_bytes;
                  state      <= DONE;
               end
            end

            DONE: begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         endcase
      end
   end

   assign bus.s_ready    = s_ready_r;
   assign bus.k_in       = chunk;
   assign bus.k_in_ready = pulse;
   assign bus.k_is_last  = is_last_r;
   assign bus.k_byte_num = byte_num_r;

endmodule

// File: tb/tb_keccak_feeder.sv
// Randomized bench for keccak_feeder against a byte-stream chunking model.
module tb_keccak_feeder;

   logic clk = 1'b0;
   logic reset;
   logic busy;
   logic done;

   keccak_feeder_if bus ();

   keccak_feeder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      bit          last;
      logic [2:0]  nb;
   } word_t;

   typedef struct {
      logic [543:0] data;
      bit           last;
      logic [7:0]   nb;
   } chunk_t;

   word_t  words[$];
   chunk_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int bf_mode  = 0;
   int exp_chunks;

   logic         rst_q;
   logic         bf_q;
   bit           seen_last;
   int           pulse_cnt;
   int           first_pulse_cyc;
   logic [543:0] last_k_in;
   logic [7:0]   last_nb;

   always @(posedge clk) begin
      rst_q <= reset;
      bf_q  <= bus.k_buffer_full;
      cyc   <= cyc + 1;
   end

   task automatic check(input bit ok, input string name,
                        input logic [543:0] act, input logic [543:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected chunks: the message is a flat byte string cut into 68-byte pieces;
   // the remainder (possibly empty) is always the final chunk.
   task automatic derive_model();
      logic [7:0] bytes_q[$];
      chunk_t     c;
      int         k, n, nfull, rem;
      exp_q.delete();
      foreach (words[i]) begin
         k = words[i].last ? ((words[i].nb > 3'd4) ? 4 : int'(words[i].nb)) : 4;
         for (int j = 0; j < k; j++) bytes_q.push_back(words[i].data[31-8*j -: 8]);
      end
      n     = bytes_q.size();
      nfull = n / 68;
      rem   = n % 68;
      for (int ci = 0; ci < nfull; ci++) begin
         c.data = '0;
         for (int b = 0; b < 68; b++) c.data[543-8*b -: 8] = bytes_q[68*ci+b];
         c.last = 1'b0;
         c.nb   = 8'd0;
         exp_q.push_back(c);
      end
      c.data = '0;
      for (int b = 0; b < rem; b++) c.data[543-8*b -: 8] = bytes_q[68*nfull+b];
      c.last = 1'b1;
      c.nb   = 8'(rem);
      exp_q.push_back(c);
      exp_chunks = exp_q.size();
   endtask

   task automatic make_msg(input int len, input bit quirks);
      word_t w;
      int    nw;
      words.delete();
      nw = (len == 0) ? 1 : (len + 3) / 4;
      for (int i = 0; i < nw; i++) begin
         w.data = $urandom;
         w.last = (i == nw - 1);
         w.nb   = w.last ? 3'(len - 4*i) : 3'd0;
         if (quirks && w.last && w.nb == 3'd4 && $urandom_range(1) == 1)
            w.nb = 3'($urandom_range(7, 5));
         words.push_back(w);
      end
      if (quirks && len > 0 && len % 4 == 0 && $urandom_range(1) == 1) begin
         words[nw-1].last = 1'b0;
         w.data = $urandom;
         w.last = 1'b1;
         w.nb   = 3'd0;
         words.push_back(w);
      end
   endtask

   task automatic send_words();
      int i = 0;
      int guard = 0;
      while (i < words.size() && guard < 5000) begin
         @(negedge clk);
         bus.s_valid = ($urandom_range(3) != 0);
         bus.s_data  = words[i].data;
         bus.s_last  = words[i].last;
         bus.s_bytes = words[i].nb;
         if (bus.s_valid && bus.s_ready) i++;
         guard++;
      end
      check(i == words.size(), "send_timeout", i, words.size());
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic wait_done();
      int g = 0;
      while (done !== 1'b1 && g < 3000) begin
         @(negedge clk);
         g++;
      end
      check(done === 1'b1, "done_timeout", done, 1);
      repeat (2) @(negedge clk);
      check(exp_q.size() == 0, "chunks_left", exp_q.size(), 0);
      check(pulse_cnt == exp_chunks, "pulse_count", pulse_cnt, exp_chunks);
   endtask

   task automatic do_reset();
      exp_q.delete();
      exp_chunks = 0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_msg();
      derive_model();
      send_words();
      wait_done();
   endtask

   // Compare process: every cycle against the model queue and the protocol rules.
   initial begin
      chunk_t e;
      forever begin
         @(negedge clk);
         if (rst_q === 1'b1) begin
            check({bus.s_ready, bus.k_in_ready, bus.k_is_last, bus.k_byte_num, busy, done}
                  == {1'b1, 12'b0}, "reset_outputs",
                  {bus.s_ready, bus.k_in_ready, bus.k_is_last, bus.k_byte_num, busy, done},
                  {1'b1, 12'b0});
            check(bus.k_in == '0, "reset_k_in", bus.k_in, '0);
            seen_last = 1'b0;
            pulse_cnt = 0;
         end else if (rst_q === 1'b0) begin
            check(done == seen_last, "done_flag", done, seen_last);
            if (seen_last)
               check(!busy && !bus.s_ready, "idle_after_done", {busy, bus.s_ready}, 0);
            if (bus.k_in_ready) begin
               check(exp_q.size() != 0, "unexpected_pulse", pulse_cnt, exp_chunks);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check(bus.k_in == e.data, "chunk_data", bus.k_in, e.data);
                  check({bus.k_is_last, bus.k_byte_num} == {e.last, e.nb}, "chunk_sideband",
                        {bus.k_is_last, bus.k_byte_num}, {e.last, e.nb});
                  check(bf_q == 1'b0, "pulse_while_full", bf_q, 0);
                  if (pulse_cnt == 0) first_pulse_cyc = cyc;
                  last_k_in = bus.k_in;
                  last_nb   = bus.k_byte_num;
                  pulse_cnt++;
                  if (e.last) seen_last = 1'b1;
               end
            end else begin
               check({bus.k_is_last, bus.k_byte_num} == 9'b0, "sideband_idle",
                     {bus.k_is_last, bus.k_byte_num}, 0);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (bf_mode == 1)      bus.k_buffer_full = ($urandom_range(2) == 0);
         else if (bf_mode == 0) bus.k_buffer_full = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [543:0] held;
      int           drop_cyc;
      word_t        w;

      reset             = 1'b1;
      bus.s_data        = '0;
      bus.s_valid       = 1'b0;
      bus.s_last        = 1'b0;
      bus.s_bytes       = '0;
      bus.k_buffer_full = 1'b0;
      repeat (3) @(negedge clk);
      check(bus.s_ready == 1'b1 && busy == 1'b0 && done == 1'b0, "reset_state",
            {bus.s_ready, busy, done}, 3'b100);
      reset = 1'b0;

      // "abc"
      words.delete();
      w = '{32'h61626300, 1'b1, 3'd3};
      words.push_back(w);
      run_msg();
      check(last_nb == 8'd3, "abc_byte_num", last_nb, 3);
      check(last_k_in == {24'h616263, 520'b0}, "abc_k_in", last_k_in, {24'h616263, 520'b0});

      // Empty message
      do_reset();
      words.delete();
      w = '{32'hDEADBEEF, 1'b1, 3'd0};
      words.push_back(w);
      run_msg();
      check(last_k_in == '0 && last_nb == 8'd0, "empty_chunk", {last_nb, last_k_in}, 0);
      check(pulse_cnt == 1, "empty_pulses", pulse_cnt, 1);

      // 68 bytes: full chunk then an empty last chunk
      do_reset();
      make_msg(68, 1'b0);
      run_msg();
      check(pulse_cnt == 2, "m68_pulses", pulse_cnt, 2);
      check(last_k_in == '0 && last_nb == 8'd0, "m68_last", {last_nb, last_k_in}, 0);

      // 100 bytes
      do_reset();
      make_msg(100, 1'b0);
      run_msg();
      check(pulse_cnt == 2, "m100_pulses", pulse_cnt, 2);
      check(last_nb == 8'd32, "m100_byte_num", last_nb, 32);
      check(last_k_in[255:0] == '0, "m100_tail_zero", last_k_in[255:0], 0);

      // buffer_full held for 50 cycles while a chunk waits
      do_reset();
      bf_mode = 2;
      bus.k_buffer_full = 1'b1;
      make_msg(68, 1'b0);
      derive_model();
      send_words();
      held = bus.k_in;
      check(held == exp_q[0].data, "hold_chunk", held, exp_q[0].data);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check(!bus.s_ready && !bus.k_in_ready && bus.k_in == held, "hold_stable",
               {bus.s_ready, bus.k_in_ready}, 0);
      end
      bus.k_buffer_full = 1'b0;
      drop_cyc = cyc;
      bf_mode = 0;
      wait_done();
      check(first_pulse_cyc == drop_cyc + 1, "hold_release", first_pulse_cyc, drop_cyc + 1);

      // Reset after 5 words, then "abc"
      do_reset();
      make_msg(40, 1'b0);
      words = words[0:4];
      send_words();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check({bus.s_ready, bus.k_in_ready, busy, done} == 4'b1000 && bus.k_in == '0,
            "midreset_outputs", {bus.s_ready, bus.k_in_ready, busy, done}, 4'b1000);
      words.delete();
      w = '{32'h61626300, 1'b1, 3'd3};
      words.push_back(w);
      run_msg();
      check(last_k_in == {24'h616263, 520'b0} && last_nb == 8'd3, "midreset_abc",
            last_k_in, {24'h616263, 520'b0});

      // Randomized messages
      for (int t = 0; t < 14; t++) begin
         int len;
         do_reset();
         bf_mode = $urandom_range(1);
         case (t)
            0:       len = 67;
            1:       len = 136;
            2:       len = 64;
            3:       len = 1;
            default: len = $urandom_range(210, 0);
         endcase
         make_msg(len, 1'b1);
         run_msg();
      end
      bf_mode = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
